// File: rtl/drain_mon_pkg.sv
// drain_mon_pkg: shared widths, volume limit and saturating add for the drainage monitor
package drain_mon_pkg;
  localparam int VOL_W = 12;
  localparam int LEV_W = 8;
  localparam int HOUR_W = 5;
  localparam logic [VOL_W-1:0] VOL_MAX = 12'd4095;
  function automatic logic [VOL_W-1:0] sat_add(input logic [VOL_W-1:0] a, input logic [LEV_W-1:0] b);
    logic [VOL_W:0] s;
    s = {1'b0, a} + {{(VOL_W-LEV_W+1){1'b0}}, b};
    return s[VOL_W] ? VOL_MAX : s[VOL_W-1:0];
  endfunction
endpackage

// File: rtl/drain_monitor_if.sv
// drain_monitor_if: core-FSM enables, sample/tick strobes and monitor status outputs
interface drain_monitor_if;
  import drain_mon_pkg::*;
  logic enhours, enlev, enchange, enhist, sec_tick, lev_valid, hist_next;
  logic [LEV_W-1:0] lev_in;
  logic [VOL_W-1:0] threshold, total, hist_out;
  logic [HOUR_W-1:0] hours;
  logic [2:0] hist_count;
  logic alarmon, clear;
  modport master(
    output enhours, enlev, enchange, enhist, sec_tick, lev_valid, hist_next, lev_in, threshold,
    input alarmon, clear, total, hours, hist_out, hist_count
  );
  modport slave(
    input enhours, enlev, enchange, enhist, sec_tick, lev_valid, hist_next, lev_in, threshold,
    output alarmon, clear, total, hours, hist_out, hist_count
  );
endinterface

// File: rtl/drain_hist_buf.sv
// drain_hist_buf: circular store of daily totals with a newest-to-oldest read pointer
module drain_hist_buf import drain_mon_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [VOL_W-1:0] push_data_i,
  input  logic             enhist_i,
  input  logic             hist_next_i,
  output logic [VOL_W-1:0] hist_out_o,
  output logic [2:0]       hist_count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);
  localparam logic [PW-1:0] ONE = PW'(1);
  logic [VOL_W-1:0] mem_q [DEPTH];
  logic [VOL_W-1:0] out_q, out_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, newest, oldest;
  logic [2:0] cnt_q, cnt_d;
  logic en_q, full;
  // Until the buffer first fills, the oldest entry always sits at index 0.
  always_comb begin
    full = cnt_q == 3'(DEPTH);
    newest = wr_q == '0 ? LAST : wr_q - ONE;
    oldest = full ? wr_q : '0;
    wr_d = push_i ? (wr_q == LAST ? '0 : wr_q + ONE) : wr_q;
    cnt_d = push_i && !full ? cnt_q + 3'd1 : cnt_q;
    rd_d = enhist_i && !en_q ? newest :
           enhist_i && hist_next_i ? (rd_q == oldest ? newest : rd_q == '0 ? LAST : rd_q - ONE) : rd_q;
    out_d = cnt_q == '0 ? '0 : mem_q[rd_q];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      en_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      en_q <= enhist_i;
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= push_data_i;
  assign hist_out_o = out_q;
  assign hist_count_o = cnt_q;
endmodule

// File: rtl/drain_monitor.sv
// drain_monitor: daily drainage accumulator with hour timebase, threshold alarm and day rollover.
// Daily-total history is built only when DRAIN_MON_HIST_EN is defined.
module drain_monitor import drain_mon_pkg::*; #(
  parameter int TICKS_PER_HOUR = 3600,
  parameter int HOURS_PER_DAY = 24,
  parameter int HIST_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  drain_monitor_if.slave b
);
  localparam int TW = TICKS_PER_HOUR > 1 ? $clog2(TICKS_PER_HOUR) : 1;
  logic [TW-1:0] tick_q, tick_d;
  logic [HOUR_W-1:0] hours_q, hours_d;
  logic [VOL_W-1:0] total_q, total_d, sum, push_val;
  logic alarm_q, alarm_d, clear_q, hour_wrap, rollover, add;
  // A bag change discards a coincident sample, so the pushed value is then the pre-change total.
  always_comb begin
    add = b.enlev && b.lev_valid;
    sum = sat_add(total_q, b.lev_in);
    hour_wrap = b.enhours && b.sec_tick && tick_q == TW'(TICKS_PER_HOUR-1);
    rollover = hour_wrap && hours_q == HOUR_W'(HOURS_PER_DAY-1);
    tick_d = b.enhours && b.sec_tick ? (hour_wrap ? '0 : tick_q + TW'(1)) : tick_q;
    hours_d = rollover ? '0 : hour_wrap ? hours_q + HOUR_W'(1) : hours_q;
    push_val = add && !b.enchange ? sum : total_q;
    total_d = rollover || b.enchange ? '0 : add ? sum : total_q;
    alarm_d = rollover || b.enchange ? 1'b0 : alarm_q || (b.threshold != '0 && total_q >= b.threshold);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q <= '0;
      hours_q <= '0;
      total_q <= '0;
      alarm_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
      hours_q <= hours_d;
      total_q <= total_d;
      alarm_q <= alarm_d;
      clear_q <= rollover;
    end
  end
  assign b.total = total_q;
  assign b.hours = hours_q;
  assign b.alarmon = alarm_q;
  assign b.clear = clear_q;
`ifdef DRAIN_MON_HIST_EN
  drain_hist_buf #(.DEPTH(HIST_DEPTH)) u_hist (
    .clk(clk),
    .rst(rst),
    .push_i(rollover),
    .push_data_i(push_val),
    .enhist_i(b.enhist),
    .hist_next_i(b.hist_next),
    .hist_out_o(b.hist_out),
    .hist_count_o(b.hist_count)
  );
`else
  logic unused_hist;
  assign unused_hist = ^{b.enhist, b.hist_next, push_val, 32'(HIST_DEPTH)};
  assign b.hist_out = '0;
  assign b.hist_count = '0;
`endif
endmodule

// File: tb/tb_drain_monitor.sv
// tb_drain_monitor: vector table with scoreboard plus rollover, history and reset sequences
module tb_drain_monitor;
  import drain_mon_pkg::*;
`ifdef DRAIN_MON_HIST_EN
  localparam bit HIST = 1'b1;
`else
  localparam bit HIST = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  drain_monitor_if bus();
  drain_monitor #(.TICKS_PER_HOUR(4), .HOURS_PER_DAY(2), .HIST_DEPTH(4)) dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic en;
    logic lv;
    logic [7:0] lev;
    logic chg;
    logic [11:0] thr;
    int exp_total;
    int exp_alarm;
  } vec_t;
  typedef struct {
    int total;
    int alarm;
  } exp_t;
  vec_t vt[$];
  exp_t sb[$];
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      bus.sec_tick = 1'b1;
      step();
      bus.sec_tick = 1'b0;
    end
  endtask
  task automatic add(input int lev);
    bus.lev_valid = 1'b1;
    bus.lev_in = 8'(lev);
    step();
    bus.lev_valid = 1'b0;
  endtask
  task automatic hnext();
    bus.hist_next = 1'b1;
    step();
    bus.hist_next = 1'b0;
    step();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " total"}, bus.total, 0);
    chk({tag, " hours"}, bus.hours, 0);
    chk({tag, " alarmon"}, bus.alarmon, 0);
    chk({tag, " clear"}, bus.clear, 0);
    chk({tag, " hist_out"}, bus.hist_out, 0);
    chk({tag, " hist_count"}, bus.hist_count, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    int day2[4];
    int wrap[4];
    day2 = '{310, 300, 300, 310};
    wrap = '{4, 3, 2, 5};
    bus.enhours = 0; bus.enlev = 1; bus.enchange = 0; bus.enhist = 0; bus.sec_tick = 0;
    bus.lev_valid = 0; bus.lev_in = 0; bus.threshold = 0; bus.hist_next = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    vt.push_back('{1'b0, 1'b1, 8'd50, 1'b0, 12'd0, 0, 0});
    for (int k = 1; k <= 22; k++) vt.push_back('{1'b1, 1'b1, 8'd200, 1'b0, 12'd0, k * 200 > 4095 ? 4095 : k * 200, 0});
    vt.push_back('{1'b1, 1'b1, 8'd50, 1'b1, 12'd0, 0, 0});
    vt.push_back('{1'b1, 1'b1, 8'd250, 1'b0, 12'd500, 250, 0});
    vt.push_back('{1'b1, 1'b1, 8'd250, 1'b0, 12'd500, 500, 0});
    vt.push_back('{1'b1, 1'b0, 8'd0, 1'b0, 12'd500, 500, 1});
    vt.push_back('{1'b1, 1'b0, 8'd0, 1'b0, 12'd4000, 500, 1});
    vt.push_back('{1'b1, 1'b0, 8'd0, 1'b1, 12'd500, 0, 0});
    vt.push_back('{1'b1, 1'b0, 8'd0, 1'b0, 12'd500, 0, 0});
    foreach (vt[i]) begin
      bus.enlev = vt[i].en; bus.lev_valid = vt[i].lv; bus.lev_in = vt[i].lev;
      bus.enchange = vt[i].chg; bus.threshold = vt[i].thr; bus.sec_tick = 1'b1;
      sb.push_back('{vt[i].exp_total, vt[i].exp_alarm});
      step();
      e = sb.pop_front();
      chk($sformatf("vec%0d total", i), bus.total, e.total);
      chk($sformatf("vec%0d alarmon", i), bus.alarmon, e.alarm);
    end
    bus.enlev = 1; bus.lev_valid = 0; bus.enchange = 0; bus.threshold = 0; bus.sec_tick = 0;
    chk("hours held while enhours=0", bus.hours, 0);
    add(200); add(100);
    chk("day1 total", bus.total, 300);
    bus.enhours = 1;
    ticks(4);
    chk("day1 hours after 4 ticks", bus.hours, 1);
    ticks(3);
    chk("day1 clear before wrap", bus.clear, 0);
    ticks(1);
    chk("day1 clear at rollover", bus.clear, 1);
    chk("day1 hours at rollover", bus.hours, 0);
    chk("day1 total at rollover", bus.total, 0);
    step();
    chk("day1 clear one cycle", bus.clear, 0);
    chk("day1 hist_count", bus.hist_count, HIST ? 1 : 0);
    bus.enhist = 1; step(); step();
    chk("day1 hist_out", bus.hist_out, HIST ? 300 : 0);
    bus.enhist = 0;
    add(200); add(100);
    ticks(7);
    bus.lev_valid = 1; bus.lev_in = 10;
    ticks(1);
    bus.lev_valid = 0;
    chk("day2 total with coincident sample", bus.total, 0);
    chk("day2 clear", bus.clear, 1);
    add(200); add(100);
    ticks(7);
    bus.enchange = 1;
    ticks(1);
    bus.enchange = 0;
    chk("day3 total with coincident change", bus.total, 0);
    chk("day3 hours", bus.hours, 0);
    chk("day3 hist_count", bus.hist_count, HIST ? 3 : 0);
    bus.enhist = 1; step(); step();
    chk("day3 read newest", bus.hist_out, HIST ? 300 : 0);
    for (int i = 0; i < 3; i++) begin
      hnext();
      chk($sformatf("day3 read step%0d", i + 1), bus.hist_out, HIST ? day2[i] : 0);
    end
    bus.enhist = 0;
    add(77);
    ticks(4);
    chk("midday hours", bus.hours, 1);
    chk("midday total", bus.total, 77);
    #2 rst = 1'b0;
    #1 chk_zero("async reset");
    @(posedge clk);
    #1 rst = 1'b1;
    for (int d = 1; d <= 5; d++) begin
      add(d);
      ticks(8);
    end
    chk("wrap hist_count", bus.hist_count, HIST ? 4 : 0);
    bus.enhist = 1; step(); step();
    chk("wrap read newest", bus.hist_out, HIST ? 5 : 0);
    for (int i = 0; i < 4; i++) begin
      hnext();
      chk($sformatf("wrap read step%0d", i + 1), bus.hist_out, HIST ? wrap[i] : 0);
    end
    bus.enhist = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
